// File: rtl/spimaster_if.sv
// Host-side control/data bundle between the command logic and the SPI master.
// Latency: none (wires only).
// Backpressure: the host may raise start only while ready=1; any other start is dropped.
// Signals: start/hold/txdata come from the host; rxdata/rx_valid/firstbyte/ready/busy go back to it.
// Modports: master = host side, slave = SPI master block.
interface spimaster_if;
  logic       start;
  logic       hold;
  logic [7:0] txdata;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       firstbyte;
  logic       ready;
  logic       busy;

  modport master (
    output start, hold, txdata,
    input  rxdata, rx_valid, firstbyte, ready, busy
  );

  modport slave (
    input  start, hold, txdata,
    output rxdata, rx_valid, firstbyte, ready, busy
  );
endinterface

// File: rtl/spimaster.sv
// Byte-wide SPI master, mode 0 (SCK idle low, sample on rise, shift on fall), MSB first.
// Latency: rx_valid fires 16*CLKDIV cycles after the edge that accepts start.
// Backpressure: start is honoured only while ready=1 (IDLE or HOLD); otherwise it is dropped.
// Ports: clk, rst (sync, active high); host = spimaster_if.slave bundle;
//        sck/mosi/cs (active low) driven to the pins, miso already synchronous to clk.
// All outputs come straight from flops; nothing combinational reaches a pin.
module spimaster #(
  parameter int CLKDIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  spimaster_if.slave  host,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs
);

  localparam int            CW      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD, SHIFT_H, SHIFT_L, HOLD, TRAIL, GAP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    tx_sr, tx_nxt;
  logic [7:0]    rx_sr, rx_nxt;
  logic [7:0]    rxdata_nxt;
  logic          first, first_nxt;
  logic          sck_nxt, mosi_nxt, cs_nxt;
  logic          rx_valid_nxt, firstbyte_nxt, ready_nxt;
  logic          tick, accept;

  // tick marks the last cycle of a half-period (or of LEAD/TRAIL/GAP)
  assign tick   = (cnt == CNT_MAX);
  assign accept = host.start && ((state == IDLE) || (state == HOLD));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + CW'(1);
    bit_nxt       = bit_cnt;
    tx_nxt        = tx_sr;
    rx_nxt        = rx_sr;
    first_nxt     = first;
    sck_nxt       = sck;
    mosi_nxt      = mosi;
    cs_nxt        = cs;
    rxdata_nxt    = host.rxdata;
    rx_valid_nxt  = 1'b0;
    firstbyte_nxt = host.firstbyte;
    ready_nxt     = 1'b0;

    if (accept) begin
      // Same acceptance from IDLE and HOLD; only IDLE opens a new frame.
      state_nxt = LEAD;
      cnt_nxt   = '0;
      bit_nxt   = '0;
      tx_nxt    = host.txdata;
      mosi_nxt  = host.txdata[7];
      cs_nxt    = 1'b0;
      sck_nxt   = 1'b0;
      first_nxt = (state == IDLE);
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          cs_nxt    = 1'b1;
          sck_nxt   = 1'b0;
          ready_nxt = 1'b1;
        end
        LEAD, SHIFT_L: begin
          if (tick) begin
            state_nxt = SHIFT_H;
            cnt_nxt   = '0;
            sck_nxt   = 1'b1;
            rx_nxt    = {rx_sr[6:0], miso};
          end
        end
        SHIFT_H: begin
          if (tick) begin
            cnt_nxt = '0;
            sck_nxt = 1'b0;
            bit_nxt = bit_cnt + 3'd1;  // wraps to 0 after the eighth bit
            if (bit_cnt == 3'd7) begin
              // Final falling edge is the byte-done edge; mosi keeps bit 0.
              state_nxt     = host.hold ? HOLD : TRAIL;
              rxdata_nxt    = rx_sr;
              rx_valid_nxt  = 1'b1;
              firstbyte_nxt = first;
              first_nxt     = 1'b0;
              ready_nxt     = host.hold;
            end else begin
              state_nxt = SHIFT_L;
              tx_nxt    = {tx_sr[6:0], 1'b0};
              mosi_nxt  = tx_sr[6];
            end
          end
        end
        HOLD: begin
          cnt_nxt = '0;
          if (!host.hold) state_nxt = TRAIL;
          else            ready_nxt = 1'b1;
        end
        TRAIL: begin
          if (tick) begin
            state_nxt = GAP;
            cnt_nxt   = '0;
            cs_nxt    = 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ready_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
      first          <= 1'b0;
      sck            <= 1'b0;
      mosi           <= 1'b0;
      cs             <= 1'b1;
      host.rxdata    <= '0;
      host.rx_valid  <= 1'b0;
      host.firstbyte <= 1'b0;
      host.ready     <= 1'b1;
      host.busy      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bit_cnt        <= bit_nxt;
      tx_sr          <= tx_nxt;
      rx_sr          <= rx_nxt;
      first          <= first_nxt;
      sck            <= sck_nxt;
      mosi           <= mosi_nxt;
      cs             <= cs_nxt;
      host.rxdata    <= rxdata_nxt;
      host.rx_valid  <= rx_valid_nxt;
      host.firstbyte <= firstbyte_nxt;
      host.ready     <= ready_nxt;
      host.busy      <= !ready_nxt;
    end
  end

endmodule
